mem_wb_stage: RTL and testbench

//  MEM/WB pipeline register plus write-back logic for the 5-stage MIPS core.
//  - Captures the data-memory read data, ALU result, destination register and WB controls from the MEM stage.
//  - Applies load-size extraction (byte/half, signed/unsigned) and selects memory or ALU data for the register file.
//  - Drives register-file write port and forwarding value; counts retired instructions.

---
 rtl/mem_wb_stage.sv | 146 ++++++++++++++
 tb/tb_mem_wb_stage.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register with load-lane extraction, write-back select,
// register-file write gating and a retired-instruction counter.
module mem_wb_stage #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              flush,
  input  logic              MEM_valid,
  input  logic [DATA_W-1:0] MEM_ReadData,
  input  logic [DATA_W-1:0] MEM_ALU_result,
  input  logic [4:0]        MEM_RegDest,
  input  logic              RegWrite,
  input  logic              MemtoReg,
  input  logic [2:0]        LoadType,
  output logic [DATA_W-1:0] WB_WriteData,
  output logic [4:0]        WB_RegDest,
  output logic              WB_RegWrite,
  output logic              WB_valid,
  output logic              WB_misaligned,
  output logic [CNT_W-1:0]  retire_count
);

  localparam logic [2:0] LT_LW  = 3'b000;
  localparam logic [2:0] LT_LB  = 3'b001;
  localparam logic [2:0] LT_LBU = 3'b010;
  localparam logic [2:0] LT_LH  = 3'b011;
  localparam logic [2:0] LT_LHU = 3'b100;

  logic              valid_q,      valid_d;
  logic [DATA_W-1:0] read_data_q,  read_data_d;
  logic [DATA_W-1:0] alu_result_q, alu_result_d;
  logic [4:0]        reg_dest_q,   reg_dest_d;
  logic              reg_write_q,  reg_write_d;
  logic              mem_to_reg_q, mem_to_reg_d;
  logic [2:0]        load_type_q,  load_type_d;
  logic [CNT_W-1:0]  retire_cnt_q, retire_cnt_d;

  // Big-endian lane selection: address 0 addresses the most significant byte.
  function automatic logic [DATA_W-1:0] load_extract(
    input logic [DATA_W-1:0] word,
    input logic [1:0]        addr,
    input logic [2:0]        ltype
  );
    logic signed [7:0]        byte_s;
    logic signed [15:0]       half_s;
    logic signed [DATA_W-1:0] wide_s;
    logic [DATA_W-1:0]        result;
    case (addr)
      2'b00:   byte_s = word[31:24];
      2'b01:   byte_s = word[23:16];
      2'b10:   byte_s = word[15:8];
      default: byte_s = word[7:0];
    endcase
    half_s = addr[1] ? word[15:0] : word[31:16];
    case (ltype)
      LT_LB: begin
        wide_s = byte_s;
        result = wide_s;
      end
      LT_LBU: result = {{(DATA_W-8){1'b0}}, byte_s};
      LT_LH: begin
        wide_s = half_s;
        result = wide_s;
      end
      LT_LHU:  result = {{(DATA_W-16){1'b0}}, half_s};
      default: result = word;
    endcase
    return result;
  endfunction

  function automatic logic is_misaligned(
    input logic [1:0] addr,
    input logic [2:0] ltype
  );
    logic mis;
    mis = 1'b0;
    if (ltype == LT_LW)
      mis = (addr != 2'b00);
    else if ((ltype == LT_LH) || (ltype == LT_LHU))
      mis = addr[0];
    return mis;
  endfunction

  // Next-state for the MEM/WB register; flush outranks stall.
  always_comb begin
    valid_d      = valid_q;
    read_data_d  = read_data_q;
    alu_result_d = alu_result_q;
    reg_dest_d   = reg_dest_q;
    reg_write_d  = reg_write_q;
    mem_to_reg_d = mem_to_reg_q;
    load_type_d  = load_type_q;
    retire_cnt_d = retire_cnt_q;
    if (flush) begin
      valid_d     = 1'b0;
      reg_write_d = 1'b0;
    end else if (!stall) begin
      valid_d      = MEM_valid;
      read_data_d  = MEM_ReadData;
      alu_result_d = MEM_ALU_result;
      reg_dest_d   = MEM_RegDest;
      reg_write_d  = RegWrite;
      mem_to_reg_d = MemtoReg;
      load_type_d  = LoadType;
      if (MEM_valid)
        retire_cnt_d = retire_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q      <= 1'b0;
      read_data_q  <= '0;
      alu_result_q <= '0;
      reg_dest_q   <= '0;
      reg_write_q  <= 1'b0;
      mem_to_reg_q <= 1'b0;
      load_type_q  <= '0;
      retire_cnt_q <= '0;
    end else begin
      valid_q      <= valid_d;
      read_data_q  <= read_data_d;
      alu_result_q <= alu_result_d;
      reg_dest_q   <= reg_dest_d;
      reg_write_q  <= reg_write_d;
      mem_to_reg_q <= mem_to_reg_d;
      load_type_q  <= load_type_d;
      retire_cnt_q <= retire_cnt_d;
    end
  end

  // Write-back outputs are combinational from the stage register.
  always_comb begin
    WB_WriteData  = mem_to_reg_q ? load_extract(read_data_q, alu_result_q[1:0], load_type_q)
                                 : alu_result_q;
    WB_RegDest    = reg_dest_q;
    WB_RegWrite   = reg_write_q & valid_q & (reg_dest_q != 5'd0);
    WB_valid      = valid_q;
    WB_misaligned = valid_q & mem_to_reg_q & is_misaligned(alu_result_q[1:0], load_type_q);
    retire_count  = retire_cnt_q;
  end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage; counter width reduced to 4 bits to reach wrap quickly.
module tb_mem_wb_stage;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        flush;
  logic        MEM_valid;
  logic [31:0] MEM_ReadData;
  logic [31:0] MEM_ALU_result;
  logic [4:0]  MEM_RegDest;
  logic        RegWrite;
  logic        MemtoReg;
  logic [2:0]  LoadType;
  logic [31:0] WB_WriteData;
  logic [4:0]  WB_RegDest;
  logic        WB_RegWrite;
  logic        WB_valid;
  logic        WB_misaligned;
  logic [3:0]  retire_count;

  int n_cmp;
  int n_fail;

  mem_wb_stage #(.DATA_W(32), .CNT_W(4)) dut (
    .clk            (clk),
    .reset          (reset),
    .stall          (stall),
    .flush          (flush),
    .MEM_valid      (MEM_valid),
    .MEM_ReadData   (MEM_ReadData),
    .MEM_ALU_result (MEM_ALU_result),
    .MEM_RegDest    (MEM_RegDest),
    .RegWrite       (RegWrite),
    .MemtoReg       (MemtoReg),
    .LoadType       (LoadType),
    .WB_WriteData   (WB_WriteData),
    .WB_RegDest     (WB_RegDest),
    .WB_RegWrite    (WB_RegWrite),
    .WB_valid       (WB_valid),
    .WB_misaligned  (WB_misaligned),
    .retire_count   (retire_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] rd, input logic [31:0] alu,
                       input logic [4:0] dst, input logic rw, input logic m2r,
                       input logic [2:0] lt);
    MEM_valid      = v;
    MEM_ReadData   = rd;
    MEM_ALU_result = alu;
    MEM_RegDest    = dst;
    RegWrite       = rw;
    MemtoReg       = m2r;
    LoadType       = lt;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    stall = 1'b0;
    flush = 1'b0;
    drive(1'b1, 32'hA5A5_A5A5, 32'h0000_0003, 5'd7, 1'b1, 1'b1, 3'b000);
    step();
    step();
    n_cmp++;
    if (WB_WriteData !== 32'h0) begin n_fail++; $display("FAIL reset_data: got %h expected %h", WB_WriteData, 32'h0); end
    n_cmp++;
    if (WB_RegDest !== 5'd0) begin n_fail++; $display("FAIL reset_dest: got %0d expected 0", WB_RegDest); end
    n_cmp++;
    if ({WB_RegWrite, WB_valid, WB_misaligned} !== 3'b000) begin
      n_fail++; $display("FAIL reset_ctrl: got %b expected 000", {WB_RegWrite, WB_valid, WB_misaligned});
    end
    n_cmp++;
    if (retire_count !== 4'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", retire_count); end
    reset = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 3'b000);
    step();
  endtask

  task automatic test_alu();
    drive(1'b1, 32'hFFFF_FFFF, 32'h0000_1234, 5'd8, 1'b1, 1'b0, 3'b000);
    step();
    n_cmp++;
    if (WB_WriteData !== 32'h0000_1234) begin n_fail++; $display("FAIL alu_data: got %h expected %h", WB_WriteData, 32'h1234); end
    n_cmp++;
    if (WB_RegDest !== 5'd8) begin n_fail++; $display("FAIL alu_dest: got %0d expected 8", WB_RegDest); end
    n_cmp++;
    if ({WB_RegWrite, WB_valid, WB_misaligned} !== 3'b110) begin
      n_fail++; $display("FAIL alu_ctrl: got %b expected 110", {WB_RegWrite, WB_valid, WB_misaligned});
    end
    n_cmp++;
    if (retire_count !== 4'd1) begin n_fail++; $display("FAIL alu_count: got %0d expected 1", retire_count); end
  endtask

  task automatic test_loads();
    drive(1'b1, 32'h1180_2233, 32'h0000_1009, 5'd9, 1'b1, 1'b1, 3'b001);
    step();
    n_cmp++;
    if (WB_WriteData !== 32'hFFFF_FF80) begin n_fail++; $display("FAIL lb_lane1: got %h expected %h", WB_WriteData, 32'hFFFF_FF80); end
    drive(1'b1, 32'h1180_2233, 32'h0000_1009, 5'd9, 1'b1, 1'b1, 3'b010);
    step();
    n_cmp++;
    if (WB_WriteData !== 32'h0000_0080) begin n_fail++; $display("FAIL lbu_lane1: got %h expected %h", WB_WriteData, 32'h80); end
    drive(1'b1, 32'h1234_8001, 32'h0000_100A, 5'd10, 1'b1, 1'b1, 3'b011);
    step();
    n_cmp++;
    if (WB_WriteData !== 32'hFFFF_8001) begin n_fail++; $display("FAIL lh_low: got %h expected %h", WB_WriteData, 32'hFFFF_8001); end
    n_cmp++;
    if (WB_misaligned !== 1'b0) begin n_fail++; $display("FAIL lh_aligned: got %b expected 0", WB_misaligned); end
    drive(1'b1, 32'h8765_8001, 32'h0000_1008, 5'd10, 1'b1, 1'b1, 3'b100);
    step();
    n_cmp++;
    if (WB_WriteData !== 32'h0000_8765) begin n_fail++; $display("FAIL lhu_high: got %h expected %h", WB_WriteData, 32'h8765); end
    drive(1'b1, 32'h1180_22F3, 32'h0000_100B, 5'd11, 1'b1, 1'b1, 3'b001);
    step();
    n_cmp++;
    if (WB_WriteData !== 32'hFFFF_FFF3) begin n_fail++; $display("FAIL lb_lane3: got %h expected %h", WB_WriteData, 32'hFFFF_FFF3); end
    drive(1'b1, 32'h7F80_22F3, 32'h0000_1000, 5'd11, 1'b1, 1'b1, 3'b001);
    step();
    n_cmp++;
    if (WB_WriteData !== 32'h0000_007F) begin n_fail++; $display("FAIL lb_lane0: got %h expected %h", WB_WriteData, 32'h7F); end
    n_cmp++;
    if (retire_count !== 4'd7) begin n_fail++; $display("FAIL loads_count: got %0d expected 7", retire_count); end
  endtask

  task automatic test_zero_and_misalign();
    drive(1'b1, 32'h0, 32'h0000_00AB, 5'd0, 1'b1, 1'b0, 3'b000);
    step();
    n_cmp++;
    if (WB_RegWrite !== 1'b0) begin n_fail++; $display("FAIL zero_dest_we: got %b expected 0", WB_RegWrite); end
    n_cmp++;
    if (WB_valid !== 1'b1) begin n_fail++; $display("FAIL zero_dest_valid: got %b expected 1", WB_valid); end
    drive(1'b1, 32'hDEAD_BEEF, 32'h0000_1006, 5'd3, 1'b1, 1'b1, 3'b000);
    step();
    n_cmp++;
    if (WB_misaligned !== 1'b1) begin n_fail++; $display("FAIL lw_misaligned: got %b expected 1", WB_misaligned); end
    n_cmp++;
    if (WB_WriteData !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL lw_mis_data: got %h expected %h", WB_WriteData, 32'hDEAD_BEEF); end
    drive(1'b1, 32'hCAFE_0001, 32'h0000_1001, 5'd4, 1'b1, 1'b1, 3'b011);
    step();
    n_cmp++;
    if ({WB_misaligned, WB_WriteData} !== {1'b1, 32'hFFFF_CAFE}) begin
      n_fail++; $display("FAIL lh_misaligned: got %b/%h expected 1/%h", WB_misaligned, WB_WriteData, 32'hFFFF_CAFE);
    end
    drive(1'b1, 32'hDEAD_BEEF, 32'h0000_1006, 5'd3, 1'b1, 1'b0, 3'b000);
    step();
    n_cmp++;
    if (WB_misaligned !== 1'b0) begin n_fail++; $display("FAIL alu_not_misaligned: got %b expected 0", WB_misaligned); end
    drive(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 3'b000);
    step();
    n_cmp++;
    if ({WB_valid, WB_misaligned, WB_RegWrite} !== 3'b000) begin
      n_fail++; $display("FAIL bubble_ctrl: got %b expected 000", {WB_valid, WB_misaligned, WB_RegWrite});
    end
    n_cmp++;
    if (retire_count !== 4'd11) begin n_fail++; $display("FAIL misalign_count: got %0d expected 11", retire_count); end
  endtask

  task automatic test_stall_flush();
    drive(1'b1, 32'h0, 32'h0000_0055, 5'd5, 1'b1, 1'b0, 3'b000);
    step();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h1111_0000 + i, 32'h2222_0000 + i, 5'd20 + 5'(i), 1'b1, 1'b0, 3'b000);
      step();
      n_cmp++;
      if ({WB_WriteData, WB_RegDest, WB_valid, WB_RegWrite} !== {32'h0000_0055, 5'd5, 1'b1, 1'b1}) begin
        n_fail++; $display("FAIL stall_hold[%0d]: got %h/%0d/%b%b expected 55/5/11", i, WB_WriteData, WB_RegDest, WB_valid, WB_RegWrite);
      end
      n_cmp++;
      if (retire_count !== 4'd12) begin n_fail++; $display("FAIL stall_count[%0d]: got %0d expected 12", i, retire_count); end
    end
    flush = 1'b1;
    step();
    n_cmp++;
    if ({WB_valid, WB_RegWrite} !== 2'b00) begin n_fail++; $display("FAIL stall_flush_ctrl: got %b expected 00", {WB_valid, WB_RegWrite}); end
    n_cmp++;
    if (retire_count !== 4'd12) begin n_fail++; $display("FAIL stall_flush_count: got %0d expected 12", retire_count); end
    stall = 1'b0;
    step();
    n_cmp++;
    if ({WB_valid, retire_count} !== {1'b0, 4'd12}) begin
      n_fail++; $display("FAIL flush_only: got %b/%0d expected 0/12", WB_valid, retire_count);
    end
    flush = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 3'b000);
    step();
  endtask

  task automatic test_wrap();
    stall = 1'b1;
    flush = 1'b1;
    reset = 1'b1;
    drive(1'b1, 32'h0, 32'h0000_0077, 5'd7, 1'b1, 1'b0, 3'b000);
    step();
    n_cmp++;
    if ({WB_valid, WB_RegWrite, WB_WriteData, retire_count} !== {1'b0, 1'b0, 32'h0, 4'd0}) begin
      n_fail++; $display("FAIL reset_wins: got %b%b/%h/%0d expected 00/0/0", WB_valid, WB_RegWrite, WB_WriteData, retire_count);
    end
    reset = 1'b0;
    stall = 1'b0;
    flush = 1'b0;
    for (int i = 0; i < 15; i++) begin
      drive(1'b1, 32'h0, 32'(i), 5'd1, 1'b1, 1'b0, 3'b000);
      step();
    end
    n_cmp++;
    if (retire_count !== 4'd15) begin n_fail++; $display("FAIL count_max: got %0d expected 15", retire_count); end
    drive(1'b1, 32'h0, 32'h0000_00EE, 5'd2, 1'b1, 1'b0, 3'b000);
    step();
    n_cmp++;
    if (retire_count !== 4'd0) begin n_fail++; $display("FAIL count_wrap: got %0d expected 0", retire_count); end
    n_cmp++;
    if (WB_WriteData !== 32'h0000_00EE) begin n_fail++; $display("FAIL wrap_data: got %h expected %h", WB_WriteData, 32'hEE); end
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    test_reset();
    test_alu();
    test_loads();
    test_zero_and_misalign();
    test_stall_flush();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
